// File: rtl/frame_source_pkg.sv
// Shared register map, STATUS bit positions and FSM encoding for the frame source.
package frame_source_pkg;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_FCOUNT = 2;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: MM-side write port, stream-side read port with 1-cycle latency.
module frame_ram #(
    parameter int unsigned DEPTH = 76800,
    parameter int unsigned AW    = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/avalon_st_frame_source.sv
// Host-loaded frame buffer replayed as one Avalon-ST packet in raster order at up to 1 pixel/cycle.
module avalon_st_frame_source
    import frame_source_pkg::*;
#(
    parameter int unsigned IMG_X_SIZE = 320,
    parameter int unsigned IMG_Y_SIZE = 240,
    parameter int unsigned ADDR_W     = 18
) (
    input  logic              csi_clkrst_clk,
    input  logic              csi_clkrst_reset_n,
    input  logic [ADDR_W-1:0] avs_s1_address,
    input  logic              avs_s1_write,
    input  logic [31:0]       avs_s1_writedata,
    input  logic              avs_s1_read,
    output logic [31:0]       avs_s1_readdata,
    input  logic              aso_source1_ready,
    output logic [7:0]        aso_source1_data,
    output logic              aso_source1_valid,
    output logic              aso_source1_startofpacket,
    output logic              aso_source1_endofpacket
);

    localparam int unsigned N     = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OFF_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx, next_idx;
    logic               done, next_done;
    logic [31:0]        fcount, next_fcount;
    logic               next_valid, next_sop, next_eop;
    logic [IDX_W-1:0]   ram_raddr;
    logic [7:0]         ram_rdata;

    logic               is_reg;
    logic [OFF_W-1:0]   offset;
    logic               busy;
    logic               pix_in_range;
    logic               pix_we;
    logic               wr_ctrl, wr_status;
    logic               start;
    logic               fire;
    logic               unused_wdata;

    assign is_reg       = avs_s1_address[ADDR_W-1];
    assign offset       = avs_s1_address[OFF_W-1:0];
    assign busy         = (state != ST_IDLE);
    assign pix_in_range = ({1'b0, offset} < (OFF_W + 1)'(N));
    // The buffer is frozen for the whole frame so the stream never sees a torn image.
    assign pix_we       = avs_s1_write && !is_reg && pix_in_range && !busy;
    assign wr_ctrl      = avs_s1_write && is_reg && (offset == OFF_W'(REG_CTRL));
    assign wr_status    = avs_s1_write && is_reg && (offset == OFF_W'(REG_STATUS));
    assign start        = wr_ctrl && avs_s1_writedata[0];
    assign fire         = aso_source1_valid && aso_source1_ready;
    assign unused_wdata = ^avs_s1_writedata[31:8];

    frame_ram #(
        .DEPTH (N),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (csi_clkrst_clk),
        .we    (pix_we),
        .waddr (IDX_W'(offset)),
        .wdata (avs_s1_writedata[7:0]),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // State, index, status and stream flag registers.
    always_ff @(posedge csi_clkrst_clk or negedge csi_clkrst_reset_n) begin
        if (!csi_clkrst_reset_n) begin
            state                     <= ST_IDLE;
            idx                       <= '0;
            done                      <= 1'b0;
            fcount                    <= '0;
            aso_source1_valid         <= 1'b0;
            aso_source1_startofpacket <= 1'b0;
            aso_source1_endofpacket   <= 1'b0;
        end else begin
            state                     <= next_state;
            idx                       <= next_idx;
            done                      <= next_done;
            fcount                    <= next_fcount;
            aso_source1_valid         <= next_valid;
            aso_source1_startofpacket <= next_sop;
            aso_source1_endofpacket   <= next_eop;
        end
    end

    // Next-state logic; the RAM reads one pixel ahead so a steady ready gives no bubbles.
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        next_done   = done;
        next_fcount = fcount;
        ram_raddr   = idx;

        if (wr_status) begin
            next_done = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_PREFETCH;
                    next_idx   = '0;
                    next_done  = 1'b0;
                end
            end
            ST_PREFETCH: begin
                ram_raddr  = '0;
                next_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (fire) begin
                    if (idx == LAST_IDX) begin
                        next_state  = ST_IDLE;
                        next_idx    = '0;
                        next_done   = 1'b1;
                        next_fcount = fcount + 32'd1;
                    end else begin
                        next_idx  = idx + IDX_W'(1);
                        ram_raddr = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        next_valid = (next_state == ST_STREAM);
        next_sop   = next_valid && (next_idx == '0);
        next_eop   = next_valid && (next_idx == LAST_IDX);
    end

    // RAM output has no reset, so mask it while no beat is presented.
    assign aso_source1_data = aso_source1_valid ? ram_rdata : 8'h00;

    // Zero-latency register readback; pixel region and unmapped offsets read 0.
    always_comb begin
        avs_s1_readdata = '0;
        if (avs_s1_read && is_reg) begin
            if (offset == OFF_W'(REG_STATUS)) begin
                avs_s1_readdata[STAT_BUSY_BIT] = busy;
                avs_s1_readdata[STAT_DONE_BIT] = done;
            end else if (offset == OFF_W'(REG_FCOUNT)) begin
                avs_s1_readdata = fcount;
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_frame_source.sv
// Directed self-checking bench: 4x2 frame instance plus a 1x1 instance for the single-beat case.
module tb_avalon_st_frame_source;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] addr0, addr1;
    logic          wr0, wr1, rd0, rd1;
    logic [31:0]   wd0, wd1, rdd0, rdd1;
    logic          rdy0, rdy1;
    logic [7:0]    dat0, dat1;
    logic          vld0, vld1, sop0, sop1, eop0, eop1;

    avalon_st_frame_source #(.IMG_X_SIZE(4), .IMG_Y_SIZE(2), .ADDR_W(AW)) dut (
        .csi_clkrst_clk            (clk),
        .csi_clkrst_reset_n        (rst_n),
        .avs_s1_address            (addr0),
        .avs_s1_write              (wr0),
        .avs_s1_writedata          (wd0),
        .avs_s1_read               (rd0),
        .avs_s1_readdata           (rdd0),
        .aso_source1_ready         (rdy0),
        .aso_source1_data          (dat0),
        .aso_source1_valid         (vld0),
        .aso_source1_startofpacket (sop0),
        .aso_source1_endofpacket   (eop0)
    );

    avalon_st_frame_source #(.IMG_X_SIZE(1), .IMG_Y_SIZE(1), .ADDR_W(AW)) dut1 (
        .csi_clkrst_clk            (clk),
        .csi_clkrst_reset_n        (rst_n),
        .avs_s1_address            (addr1),
        .avs_s1_write              (wr1),
        .avs_s1_writedata          (wd1),
        .avs_s1_read               (rd1),
        .avs_s1_readdata           (rdd1),
        .aso_source1_ready         (rdy1),
        .aso_source1_data          (dat1),
        .aso_source1_valid         (vld1),
        .aso_source1_startofpacket (sop1),
        .aso_source1_endofpacket   (eop1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_pix [8];
    logic [7:0] bdata [$];
    bit         bsop [$];
    bit         beop [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input bit sel, input logic [AW-1:0] a, input logic [31:0] d);
        if (sel) begin addr1 = a; wd1 = d; wr1 = 1'b1; end
        else     begin addr0 = a; wd0 = d; wr0 = 1'b1; end
        step();
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic mm_read(input bit sel, input logic [AW-1:0] a, output logic [31:0] d);
        if (sel) begin addr1 = a; rd1 = 1'b1; #1; d = rdd1; rd1 = 1'b0; end
        else     begin addr0 = a; rd0 = 1'b1; #1; d = rdd0; rd0 = 1'b0; end
    endtask

    task automatic read_check(input bit sel, input logic [AW-1:0] a, input string tag,
                              input logic [31:0] exp);
        logic [31:0] d;
        mm_read(sel, a, d);
        check(tag, d, exp);
    endtask

    task automatic sample(input bit sel, output logic v, output logic [7:0] dt,
                          output logic sp, output logic ep);
        if (sel) begin v = vld1; dt = dat1; sp = sop1; ep = eop1; end
        else     begin v = vld0; dt = dat0; sp = sop0; ep = eop0; end
    endtask

    // Collect fired beats; rnd selects an LFSR (seed 5) ready pattern, stop_after>0 exits early.
    task automatic capture(input bit sel, input bit rnd, input int stop_after, output int ncyc);
        logic [7:0] lfsr;
        logic       r, v, sp, ep, ps, pe;
        logic [7:0] dt, pd;
        bit         stalled, fin, seen;
        int         n;
        lfsr = 8'd5; stalled = 0; fin = 0; seen = 0; n = 0; ncyc = 0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        bdata.delete(); bsop.delete(); beop.delete();
        for (int c = 0; c < 300 && !fin; c++) begin
            if (rnd) begin
                r    = lfsr[0];
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
                r = 1'b1;
            end
            if (sel) rdy1 = r; else rdy0 = r;
            sample(sel, v, dt, sp, ep);
            if (v) seen = 1;
            if (seen) ncyc++;
            if (stalled) begin
                check("hold_valid", 32'(v), 32'd1);
                check("hold_data", 32'(dt), 32'(pd));
                check("hold_sop", 32'(sp), 32'(ps));
                check("hold_eop", 32'(ep), 32'(pe));
            end
            if (v && r) begin
                bdata.push_back(dt); bsop.push_back(sp); beop.push_back(ep);
                n++;
                if (ep || n == stop_after) fin = 1;
            end
            stalled = v && !r;
            pd = dt; ps = sp; pe = ep;
            step();
        end
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (!fin) check("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tg);
        check({tg, "_beats"}, 32'(bdata.size()), 32'd8);
        for (int i = 0; i < bdata.size() && i < 8; i++) begin
            check($sformatf("%s_data%0d", tg, i), 32'(bdata[i]), 32'(exp_pix[i]));
            check($sformatf("%s_sop%0d", tg, i), 32'(bsop[i]), 32'(i == 0));
            check($sformatf("%s_eop%0d", tg, i), 32'(beop[i]), 32'(i == 7));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        rst_n = 1'b0;
        addr0 = '0; addr1 = '0; wr0 = 0; wr1 = 0; rd0 = 0; rd1 = 0;
        wd0 = '0; wd1 = '0; rdy0 = 0; rdy1 = 0;
        repeat (3) step();
        check("rst_valid", 32'(vld0), 32'd0);
        check("rst_sop", 32'(sop0), 32'd0);
        check("rst_eop", 32'(eop0), 32'd0);
        check("rst_data", 32'(dat0), 32'd0);
        rst_n = 1'b1;
        step();
        read_check(0, 8'h81, "rst_status", 32'd0);
        read_check(0, 8'h82, "rst_fcount", 32'd0);

        // Frame with continuous ready.
        for (int i = 0; i < 8; i++) begin
            mm_write(0, AW'(i), 32'h10 + 32'(i));
            exp_pix[i] = 8'h10 + 8'(i);
        end
        mm_write(0, 8'h80, 32'd1);
        capture(0, 0, 0, nc);
        check_frame("t1");
        check("t1_cycles", 32'(nc), 32'd8);
        read_check(0, 8'h81, "t1_status", 32'h2);
        read_check(0, 8'h82, "t1_fcount", 32'd1);
        mm_write(0, 8'h81, 32'd0);
        read_check(0, 8'h81, "t1_done_clr", 32'h0);

        // Same frame under back-pressure.
        mm_write(0, 8'h80, 32'd1);
        capture(0, 1, 0, nc);
        check_frame("t2");
        read_check(0, 8'h82, "t2_fcount", 32'd2);

        // Pixel write and restart while busy are both ignored.
        mm_write(0, 8'h80, 32'd1);
        mm_write(0, 8'h03, 32'hFF);
        read_check(0, 8'h81, "t3_busy", 32'h1);
        mm_write(0, 8'h80, 32'd1);
        capture(0, 1, 0, nc);
        check_frame("t3");
        step(); step();
        check("t3_no_restart", 32'(vld0), 32'd0);
        read_check(0, 8'h82, "t3_fcount", 32'd3);
        mm_write(0, 8'h80, 32'd1);
        capture(0, 0, 0, nc);
        check_frame("t3b");
        read_check(0, 8'h82, "t3b_fcount", 32'd4);

        // Mid-frame reset.
        mm_write(0, 8'h80, 32'd1);
        capture(0, 0, 4, nc);
        check("t4_pre_valid", 32'(vld0), 32'd1);
        check("t4_pre_data", 32'(dat0), 32'h14);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 32'(vld0), 32'd0);
        check("t4_rst_eop", 32'(eop0), 32'd0);
        check("t4_rst_data", 32'(dat0), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        read_check(0, 8'h81, "t4_status", 32'd0);
        read_check(0, 8'h82, "t4_fcount", 32'd0);
        mm_write(0, 8'h80, 32'd1);
        capture(0, 0, 0, nc);
        check_frame("t4");

        // Out-of-range pixel write, unmapped registers, write-only regions.
        mm_write(0, 8'h08, 32'h99);
        for (int o = 3; o < 8; o++) mm_write(0, 8'h80 | AW'(o), 32'hFFFF_FFFF);
        for (int o = 3; o < 8; o++) read_check(0, 8'h80 | AW'(o), $sformatf("t5_off%0d", o), 32'd0);
        read_check(0, 8'h80, "t5_ctrl_rd", 32'd0);
        read_check(0, 8'h00, "t5_pix_rd", 32'd0);
        mm_write(0, 8'h80, 32'd1);
        capture(0, 0, 0, nc);
        check_frame("t5");
        read_check(0, 8'h81, "t5_status", 32'h2);
        read_check(0, 8'h82, "t5_fcount", 32'd2);

        // Single-pixel frame: SOP and EOP together, 2-cycle start latency.
        mm_write(1, 8'h00, 32'hA5);
        mm_write(1, 8'h80, 32'd1);
        check("t6_lat1_valid", 32'(vld1), 32'd0);
        step();
        check("t6_valid", 32'(vld1), 32'd1);
        check("t6_data", 32'(dat1), 32'hA5);
        check("t6_sop", 32'(sop1), 32'd1);
        check("t6_eop", 32'(eop1), 32'd1);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        check("t6_after_valid", 32'(vld1), 32'd0);
        read_check(1, 8'h81, "t6_status", 32'h2);
        read_check(1, 8'h82, "t6_fcount", 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
